// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: scoreboard entry type and shared constants for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int SB_AW = 8;
  localparam int FWD_RF = 0;
  // dst is held zero-extended to SB_AW, so REG_AW may be anything up to SB_AW
  typedef struct packed {
    logic vld;
    logic [SB_AW-1:0] dst;
    logic wr;
    logic ld;
  } sb_entry_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode-stage hazard bus between pipeline (master) and controller (slave)
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int FWD_STAGES = 3,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  logic id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic id_use_rs;
  logic id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic id_reg_write;
  logic id_is_load;
  logic id_jump;
  logic id_branch_taken;
  logic mem_ready;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_bubble;
  logic pipe_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] wait_cnt;
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write,
           id_is_load, id_jump, id_branch_taken, mem_ready,
    input  fwd_rs_sel, fwd_rt_sel, pc_en, if_id_en, if_id_flush, id_ex_bubble,
           pipe_en, stall_cnt, wait_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write,
           id_is_load, id_jump, id_branch_taken, mem_ready,
    output fwd_rs_sel, fwd_rt_sel, pc_en, if_id_en, if_id_flush, id_ex_bubble,
           pipe_en, stall_cnt, wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// sb_match: priority matcher of one source operand against the scoreboard, youngest slot wins
module sb_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 3,
  parameter int SEL_W = 2
) (
  input  sb_entry_t sb [1:FWD_STAGES],
  input  logic [REG_AW-1:0] r,
  input  logic use_r,
  output logic [SEL_W-1:0] sel,
  output logic hazard
);
  always_comb begin
    sel = SEL_W'(FWD_RF);
    hazard = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--)
      if (use_r && r != '0 && sb[k].vld && sb[k].wr && sb[k].dst == SB_AW'(r)) begin
        sel = SEL_W'(k);
        hazard = sb[k].ld && k < LOAD_STAGE;
      end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode-stage forwarding selects, load-use stalls, flush and mem-wait freeze
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  sb_entry_t sb [1:FWD_STAGES];
  sb_entry_t id_entry;
  logic hz_rs, hz_rt, hz;
  logic [CNT_W-1:0] stall_q, wait_q;
  assign id_entry = '{vld: bus.id_valid & bus.id_reg_write & (bus.id_dst != '0),
                      dst: SB_AW'(bus.id_dst), wr: bus.id_reg_write, ld: bus.id_is_load};
  sb_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_rs (
    .sb(sb), .r(bus.id_rs), .use_r(bus.id_use_rs), .sel(bus.fwd_rs_sel), .hazard(hz_rs)
  );
  sb_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) u_rt (
    .sb(sb), .r(bus.id_rt), .use_r(bus.id_use_rt), .sel(bus.fwd_rt_sel), .hazard(hz_rt)
  );
  assign hz = hz_rs | hz_rt;
  assign bus.pipe_en = bus.mem_ready;
  assign bus.pc_en = bus.mem_ready & ~hz;
  assign bus.if_id_en = bus.mem_ready & ~hz;
  assign bus.id_ex_bubble = hz;
  // a taken branch waiting on a load operand flushes only once its stall clears
  assign bus.if_id_flush = bus.mem_ready & ~hz & bus.id_valid & (bus.id_jump | bus.id_branch_taken);
  assign bus.stall_cnt = stall_q;
  assign bus.wait_cnt = wait_q;
  // the mem-wait freeze holds everything, so a pending bubble is not inserted until ready
  always_ff @(posedge clk)
    if (rst) sb <= '{default: '0};
    else if (bus.mem_ready) begin
      sb[1] <= hz ? '0 : id_entry;
      for (int i = 2; i <= FWD_STAGES; i++) sb[i] <= sb[i-1];
    end
  always_ff @(posedge clk)
    if (rst) stall_q <= '0;
    else if (bus.mem_ready && hz && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
  always_ff @(posedge clk)
    if (rst) wait_q <= '0;
    else if (!bus.mem_ready && wait_q != '1) wait_q <= wait_q + CNT_W'(1);
endmodule
